// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Purpose : Multi-cycle RV64 data-memory responder for the MEM stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [2:0]    r_size;
  logic [63:0]   r_rdata;
  logic          r_err;
  logic [63:0]   r_mem [DEPTH_WORDS];

  logic          w_fire;
  logic          w_misalign;
  logic          w_oob;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [5:0]    w_shamt;
  logic [63:0]   w_word;
  logic [63:0]   w_lanes;
  logic [63:0]   w_load;
  logic [63:0]   w_bmask;
  logic [63:0]   w_mask;
  logic [63:0]   w_merged;

  // Decode works only on the latched request copy.
  assign w_fire  = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_oob   = (r_addr[63:3] >= 61'(DEPTH_WORDS));
  assign w_idx   = r_addr[AW+2:3];
  assign w_shamt = {r_addr[2:0], 3'b000};
  assign w_word  = r_mem[w_idx];
  assign w_lanes = w_word >> w_shamt;
  assign w_mask  = w_bmask << w_shamt;
  assign w_merged = (w_word & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
  assign w_err   = (r_size == 3'b111) | (r_write & r_size[2]) | w_misalign | w_oob;

  always_comb begin
    w_misalign = 1'b0;
    w_bmask    = 64'hFFFF_FFFF_FFFF_FFFF;
    case (r_size[1:0])
      2'b00: w_bmask = 64'h0000_0000_0000_00FF;
      2'b01: begin
        w_bmask    = 64'h0000_0000_0000_FFFF;
        w_misalign = r_addr[0];
      end
      2'b10: begin
        w_bmask    = 64'h0000_0000_FFFF_FFFF;
        w_misalign = |r_addr[1:0];
      end
      default: w_misalign = |r_addr[2:0];
    endcase
  end

  always_comb begin
    w_load = 64'd0;
    case (r_size)
      3'b000:  w_load = {{56{w_lanes[7]}},  w_lanes[7:0]};
      3'b001:  w_load = {{48{w_lanes[15]}}, w_lanes[15:0]};
      3'b010:  w_load = {{32{w_lanes[31]}}, w_lanes[31:0]};
      3'b011:  w_load = w_lanes;
      3'b100:  w_load = {56'd0, w_lanes[7:0]};
      3'b101:  w_load = {48'd0, w_lanes[15:0]};
      3'b110:  w_load = {32'd0, w_lanes[31:0]};
      default: w_load = 64'd0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    stall      = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) w_next = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (r_cnt == 4'd0) w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_size  <= 3'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
        r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == BUSY) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_err   <= w_err;
          r_rdata <= (w_err || r_write) ? 64'd0 : w_load;
        end
      end
    end
  end

  // Array is never cleared; only a completed, error-free store touches it.
  always_ff @(posedge clk) begin
    if (!rst && w_fire && r_write && !w_err) r_mem[w_idx] <= w_merged;
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module  : tb_dmem_responder
// Purpose : Scoreboard bench for dmem_responder (LATENCY 2 main, LATENCY 1 throughput).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, resp_valid, resp_err, stall;
  logic [63:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_size;

  logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_err1, stall1;
  logic [63:0] req_addr1, req_wdata1, resp_rdata1;
  logic [2:0]  req_size1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(512), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall)
  );

  dmem_responder #(.DEPTH_WORDS(512), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .req_size(req_size1), .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
    .resp_err(resp_err1), .stall(stall1)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_edge = 0;
  int   stall_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) n_edge <= n_edge + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per response strobe.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (stall === 1'b1) stall_cnt++;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {63'd0, resp_err}, {63'd0, e.err});
        check("resp_latency", 64'(n_edge), 64'(e.due));
      end
    end
  end

  task automatic issue(input logic w, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [2:0] size, input logic [63:0] exp_rdata, input logic exp_err);
    int waited;
    @(posedge clk);
    #1;
    req_write = w; req_addr = addr; req_wdata = wdata; req_size = size; req_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      waited++;
      if (waited > 50) begin
        check("accept_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
        return;
      end
    end
    sb.push_back('{exp_rdata, exp_err, n_edge + 1 + LAT});
    @(posedge clk);
    #1;
    // Scramble the request bus to confirm the DUT works from its latched copy.
    req_valid = 1'b0; req_write = ~w; req_addr = 64'hDEAD_BEEF_0000_0003;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_size = 3'b111;
    @(negedge clk);
    check("req_ready_busy", {63'd0, req_ready}, 64'd0);
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      check("resp_timeout", 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  localparam logic [63:0] W0 = 64'h8877_6655_4433_2211;
  localparam logic [63:0] W1 = 64'h8877_6655_44AB_2211;
  localparam logic [63:0] WP = 64'h0123_4567_89AB_CDEF;

  initial begin : main
    int s0, waited, nacc, nresp, prev_acc, acc;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    req_valid1 = 1'b0; req_write1 = 1'b1; req_addr1 = 64'h8; req_wdata1 = 64'h55; req_size1 = 3'b011;
    #3;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    s0 = stall_cnt;
    issue(1'b1, 64'h10, W0, 3'b011, 64'd0, 1'b0);
    @(negedge clk);
    check("sd_stall_cycles", 64'(stall_cnt - s0), 64'd3);

    issue(1'b0, 64'h17, '0, 3'b000, 64'hFFFF_FFFF_FFFF_FF88, 1'b0);
    issue(1'b0, 64'h17, '0, 3'b100, 64'h0000_0000_0000_0088, 1'b0);
    issue(1'b0, 64'h16, '0, 3'b001, 64'hFFFF_FFFF_FFFF_8877, 1'b0);
    issue(1'b0, 64'h14, '0, 3'b010, 64'hFFFF_FFFF_8877_6655, 1'b0);
    issue(1'b0, 64'h14, '0, 3'b110, 64'h0000_0000_8877_6655, 1'b0);
    issue(1'b0, 64'h12, '0, 3'b101, 64'h0000_0000_0000_4433, 1'b0);
    issue(1'b0, 64'h10, '0, 3'b011, W0, 1'b0);

    issue(1'b1, 64'h12, 64'h1234_5678_9ABC_DEAB, 3'b000, 64'd0, 1'b0);
    issue(1'b0, 64'h10, '0, 3'b011, W1, 1'b0);

    issue(1'b0, 64'h12, '0, 3'b010, 64'd0, 1'b1);
    issue(1'b1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 64'd0, 1'b1);
    issue(1'b0, 64'h10, '0, 3'b111, 64'd0, 1'b1);
    issue(1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 64'd0, 1'b1);
    issue(1'b1, 64'h11, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 64'd0, 1'b1);
    issue(1'b0, 64'h10, '0, 3'b011, W1, 1'b0);

    // Reset during BUSY drops the in-flight store.
    issue(1'b1, 64'h20, WP, 3'b011, 64'd0, 1'b0);
    issue(1'b0, 64'h20, '0, 3'b011, WP, 1'b0);
    @(posedge clk);
    #1;
    req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    req_size = 3'b011; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
    check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("midrst_resp_rdata", resp_rdata, 64'd0);
    check("midrst_resp_err", {63'd0, resp_err}, 64'd0);
    check("midrst_stall", {63'd0, stall}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue(1'b0, 64'h20, '0, 3'b011, WP, 1'b0);

    // Throughput at LATENCY=1 with req_valid held high.
    @(posedge clk);
    #1;
    req_valid1 = 1'b1;
    nacc = 0; nresp = 0; prev_acc = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (resp_valid1 === 1'b1) begin
        nresp++;
        check("tp_resp_err", {63'd0, resp_err1}, 64'd0);
      end
      if (req_ready1 === 1'b1) begin
        acc = n_edge + 1;
        if (prev_acc >= 0) check("tp_accept_spacing", 64'(acc - prev_acc), 64'd3);
        prev_acc = acc;
        nacc++;
      end
    end
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    waited = 0;
    while (waited < 6) begin
      @(negedge clk);
      if (resp_valid1 === 1'b1) nresp++;
      waited++;
    end
    check("tp_accept_count", 64'(nacc), 64'd6);
    check("tp_resp_count", 64'(nresp), 64'(nacc));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
